// File: rtl/gb_pkg.sv
// Shared definitions for the DMG joypad front end: bus address, IRQ bit
// position and the index order of the packed 8-bit key vector.
package gb_pkg;

  localparam logic [15:0] P1_ADDR        = 16'hFF00;
  localparam int          JOYPAD_IRQ_BIT = 4;

  // Bit positions in the packed key vector; low nibble is the direction
  // group, high nibble the action group, each already in P1 bit order.
  typedef enum logic [2:0] {
    KEY_RIGHT  = 3'd0,
    KEY_LEFT   = 3'd1,
    KEY_UP     = 3'd2,
    KEY_DOWN   = 3'd3,
    KEY_A      = 3'd4,
    KEY_B      = 3'd5,
    KEY_SELECT = 3'd6,
    KEY_START  = 3'd7
  } key_idx_t;

endpackage

// File: rtl/joypad_ctrl_if.sv
// CPU memory-bus view of the joypad block: address/write strobe/data in,
// read data and interrupt request out.
interface joypad_ctrl_if;

  logic [15:0] addr;
  logic        wr_en;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        joypad_irq;

  // wr_en is a single-cycle strobe qualified by addr; reads are combinational.
  modport master (
    output addr, wr_en, data_in,
    input  data_out, joypad_irq
  );

  modport slave (
    input  addr, wr_en, data_in,
    output data_out, joypad_irq
  );

endinterface

// File: rtl/joypad_debounce.sv
// One key: two-flop synchroniser followed by a hold-time debouncer.
// Reset value is 1 (released) for every flop.
module joypad_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw_n,
  output logic o_stable_n
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_raw_n;
      r_sync2 <= r_sync1;
    end
  end

  // Counter only runs while the synced level disagrees with the stable one,
  // so it clears on the last step and can never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stable <= 1'b1;
      r_cnt    <= '0;
    end else if (r_sync2 != r_stable) begin
      if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_stable_n = r_stable;

endmodule

// File: rtl/joypad_ctrl.sv
// DMG P1/JOYP register: debounced keys, group select bits, combinational
// read-back at P1_ADDR and a one-cycle IRQ on any selected key falling edge.
module joypad_ctrl
  import gb_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter logic [15:0] P1_ADDR         = gb_pkg::P1_ADDR
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          joypad_up,
  input  logic          joypad_down,
  input  logic          joypad_left,
  input  logic          joypad_right,
  input  logic          joypad_a,
  input  logic          joypad_b,
  input  logic          joypad_start,
  input  logic          joypad_select,
  joypad_ctrl_if.slave  bus
);

  logic [7:0] w_raw_n;
  logic [7:0] w_keys_n;
  logic [3:0] w_dir;
  logic [3:0] w_btn;
  logic [3:0] w_nibble;
  logic       w_p1_hit;
  logic       w_unused;

  logic       r_p15;
  logic       r_p14;
  logic [3:0] r_prev_nibble;
  logic       r_irq;

  assign w_raw_n = {joypad_start, joypad_select, joypad_b, joypad_a,
                    joypad_down, joypad_up, joypad_left, joypad_right};

  for (genvar g = 0; g < 8; g++) begin : g_key
    joypad_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk        (clk),
      .rst        (rst),
      .i_raw_n    (w_raw_n[g]),
      .o_stable_n (w_keys_n[g])
    );
  end

  assign w_p1_hit = (bus.addr == P1_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p15 <= 1'b1;
      r_p14 <= 1'b1;
    end else if (bus.wr_en && w_p1_hit) begin
      r_p15 <= bus.data_in[5];
      r_p14 <= bus.data_in[4];
    end
  end

  // Select lines are active-low: a 1 masks its group to all-released.
  assign w_dir = {w_keys_n[KEY_DOWN], w_keys_n[KEY_UP],
                  w_keys_n[KEY_LEFT], w_keys_n[KEY_RIGHT]};
  assign w_btn = {w_keys_n[KEY_START], w_keys_n[KEY_SELECT],
                  w_keys_n[KEY_B], w_keys_n[KEY_A]};
  assign w_nibble = (r_p14 ? 4'hF : w_dir) & (r_p15 ? 4'hF : w_btn);

  // Any 1->0 on the visible nibble, whether from a key or a select change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_nibble <= 4'hF;
      r_irq         <= 1'b0;
    end else begin
      r_prev_nibble <= w_nibble;
      r_irq         <= |(r_prev_nibble & ~w_nibble);
    end
  end

  assign bus.data_out   = w_p1_hit ? {2'b11, r_p15, r_p14, w_nibble} : 8'h00;
  assign bus.joypad_irq = r_irq;

  assign w_unused = &{1'b0, bus.data_in[7:6], bus.data_in[3:0]};

endmodule

// File: tb/tb_joypad_ctrl.sv
// Self-checking bench for joypad_ctrl with DEBOUNCE_CYCLES=4: static P1
// vectors from a table plus timed sequences for debounce, glitch and IRQ.
module tb_joypad_ctrl;

  localparam int DB = 4;

  logic clk;
  logic rst;
  logic [7:0] keys_n;  // bit order: right,left,up,down,a,b,select,start

  joypad_ctrl_if bus();

  joypad_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .P1_ADDR        (16'hFF00)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .joypad_up     (keys_n[2]),
    .joypad_down   (keys_n[3]),
    .joypad_left   (keys_n[1]),
    .joypad_right  (keys_n[0]),
    .joypad_a      (keys_n[4]),
    .joypad_b      (keys_n[5]),
    .joypad_start  (keys_n[7]),
    .joypad_select (keys_n[6]),
    .bus           (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0]  keys_n;
    logic [7:0]  sel;
    logic [15:0] addr;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[10];

  task automatic check_val(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard: expectation queued at drive time, popped at the sample point.
  task automatic expect_data(input logic [7:0] exp);
    exp_q.push_back(exp);
  endtask

  task automatic sample_data(input string name);
    logic [7:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: scoreboard empty, got %02h", name, bus.data_out);
    end else begin
      e = exp_q.pop_front();
      if (bus.data_out !== e) begin
        n_errors++;
        $display("FAIL %s: data_out got %02h expected %02h", name, bus.data_out, e);
      end
    end
  endtask

  task automatic check_now(input string name, input logic [7:0] exp_d, input logic exp_irq);
    expect_data(exp_d);
    sample_data(name);
    check_val({name, "_irq"}, int'(bus.joypad_irq), int'(exp_irq));
  endtask

  // driver tasks: all called at a negedge, return at a negedge
  task automatic p1_write(input logic [7:0] d);
    bus.addr    = 16'hFF00;
    bus.data_in = d;
    bus.wr_en   = 1'b1;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic watch(input int n, input logic [7:0] exp_d, output int pulses, output int bad_data);
    pulses   = 0;
    bad_data = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.joypad_irq === 1'b1) pulses++;
      if (bus.data_out !== exp_d) bad_data++;
    end
  endtask

  int pulses;
  int bad;

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    keys_n      = 8'hFF;
    bus.addr    = 16'hFF00;
    bus.wr_en   = 1'b0;
    bus.data_in = 8'h00;
    rst         = 1'b1;

    vecs[0] = '{8'hFF, 8'h30, 16'hFF00, 8'hFF};
    vecs[1] = '{8'hFF, 8'h30, 16'hFF01, 8'h00};
    vecs[2] = '{8'hFE, 8'h20, 16'hFF00, 8'hEE};
    vecs[3] = '{8'hEF, 8'h10, 16'hFF00, 8'hDE};
    vecs[4] = '{8'hDF, 8'h00, 16'hFF00, 8'hCD};
    vecs[5] = '{8'h7B, 8'h00, 16'hFF00, 8'hC3};
    vecs[6] = '{8'h00, 8'h30, 16'hFF00, 8'hFF};
    vecs[7] = '{8'h00, 8'h20, 16'hFF00, 8'hE0};
    vecs[8] = '{8'h00, 8'hCF, 16'hFF00, 8'hC0};
    vecs[9] = '{8'h00, 8'h00, 16'h0000, 8'h00};

    idle(3);
    #1;
    check_now("reset_ff00", 8'hFF, 1'b0);
    rst = 1'b0;
    idle(2);
    check_now("idle_ff00", 8'hFF, 1'b0);
    bus.addr = 16'hFF01;
    #1;
    check_now("idle_ff01", 8'h00, 1'b0);

    // table-driven static reads
    for (int i = 0; i < 10; i++) begin
      keys_n = vecs[i].keys_n;
      idle(2 + DB + 2);
      p1_write(vecs[i].sel);
      bus.addr = vecs[i].addr;
      idle(2);
      expect_data(vecs[i].exp_data);
      sample_data($sformatf("vec%0d", i));
    end

    keys_n = 8'hFF;
    p1_write(8'h30);
    idle(12);

    // held up press with directions selected
    p1_write(8'h20);
    idle(4);
    keys_n[2] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check_now($sformatf("up_edge%0d", k), (k >= 6) ? 8'hEB : 8'hEF, k == 7);
    end
    keys_n[2] = 1'b1;
    watch(12, 8'hEF, pulses, bad);
    check_val("up_release_pulses", pulses, 0);
    check_now("up_released", 8'hEF, 1'b0);

    // 3-cycle glitch on A with buttons selected
    p1_write(8'h10);
    idle(4);
    keys_n[4] = 1'b0;
    idle(3);
    keys_n[4] = 1'b1;
    watch(12, 8'hDF, pulses, bad);
    check_val("glitch_pulses", pulses, 0);
    check_val("glitch_data_bad", bad, 0);

    // start held, then select the button group
    p1_write(8'h20);
    keys_n[7] = 1'b0;
    watch(10, 8'hEF, pulses, bad);
    check_val("start_dirsel_pulses", pulses, 0);
    check_val("start_dirsel_bad", bad, 0);
    p1_write(8'h10);
    check_now("start_sel_d7", 8'hD7, 1'b0);
    @(negedge clk);
    check_now("start_sel_irq", 8'hD7, 1'b1);
    watch(6, 8'hD7, pulses, bad);
    check_val("start_sel_after", pulses, 0);
    keys_n[7] = 1'b1;
    watch(12, 8'hDF, pulses, bad);
    check_val("start_release_pulses", pulses, 0);
    check_now("start_released", 8'hDF, 1'b0);

    // both groups selected
    keys_n[0] = 1'b0;
    keys_n[5] = 1'b0;
    idle(12);
    p1_write(8'h00);
    check_now("both_sel_cc", 8'hCC, 1'b0);
    idle(3);
    p1_write(8'h30);
    check_now("none_sel_ff", 8'hFF, 1'b0);
    keys_n = 8'hFF;
    idle(12);

    // reset while down is mid-debounce
    p1_write(8'h20);
    idle(4);
    keys_n[3] = 1'b0;
    idle(4);
    rst = 1'b1;
    #1;
    check_now("rst_mid_ff", 8'hFF, 1'b0);
    @(negedge clk);
    rst         = 1'b0;
    bus.addr    = 16'hFF00;
    bus.data_in = 8'h20;
    bus.wr_en   = 1'b1;
    #1;
    check_now("rst_release_ff", 8'hFF, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      bus.wr_en = 1'b0;
      check_now($sformatf("down_edge%0d", k), (k >= 6) ? 8'hE7 : 8'hEF, k == 7);
    end
    watch(6, 8'hE7, pulses, bad);
    check_val("down_after_pulses", pulses, 0);

    check_val("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/joypad_ctrl.md
Name: joypad_ctrl

Overview:
- Front end for the eight active-low joypad inputs that the top-level bench drives.
- Synchronises and debounces each button, then exposes the DMG P1/JOYP register at 0xFF00 on the CPU memory bus.
- Raises the joypad interrupt request on a falling edge of any selected key line.
- Sits between the top-level joypad pins and the datapath's memory/interrupt logic.

Parameters:
- DEBOUNCE_CYCLES, 16, clock cycles a synchronised input must hold a new level before the debounced state changes (hardware build overrides to 20950, about 5 ms at 4.19 MHz).
- P1_ADDR, 16'hFF00, bus address of the P1 register.

Ports:
- clk  input  1  system clock, 4.19 MHz.
- rst  input  1  asynchronous, active-high reset.
- joypad_up, joypad_down, joypad_left, joypad_right  input  1 each  raw direction keys, active-low (0 = pressed), asynchronous.
- joypad_a, joypad_b, joypad_start, joypad_select  input  1 each  raw action keys, active-low, asynchronous.
- addr  input  16  CPU bus address.
- wr_en  input  1  bus write strobe, one cycle.
- data_in  input  8  bus write data.
- data_out  output  8  read data; P1 value when addr==P1_ADDR, else 8'h00.
- joypad_irq  output  1  one-cycle interrupt request pulse (IF bit 4).

Behaviour:
- Reset (async, active-high):
  - sync flops and debounced states = 1 (released); counters = 0.
  - select bits P15:P14 = 2'b11.
  - prev_nibble = 4'hF; joypad_irq = 0.
  - data_out at P1_ADDR reads 8'hFF.
- Synchroniser: 2-flop per input. The raw value is visible to the debouncer 2 clocks after the pin changes.
- Debounce, per key:
  - If sync != stable, the counter increments; otherwise the counter clears to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still mismatched, stable <= sync and the counter clears.
  - A held change appears on stable exactly 2+DEBOUNCE_CYCLES clocks after the pin edge.
  - A glitch shorter than DEBOUNCE_CYCLES synced cycles produces no change.
  - Counter width = $clog2(DEBOUNCE_CYCLES)+1; it never wraps.
- P1 write: on wr_en && addr==P1_ADDR, latch data_in[5:4] into P15:P14. All other bits are ignored (read-only).
- Key nibble, combinational from debounced states and select bits:
  - dir = {down, up, left, right}.
  - btn = {start, select, b, a}.
  - nibble = (P14 ? 4'hF : dir) & (P15 ? 4'hF : btn).
  - Both selected gives the AND of both groups; neither selected gives 4'hF.
- data_out = {2'b11, P15, P14, nibble} when addr==P1_ADDR, else 8'h00. Reads are combinational with no side effects.
- Interrupt:
  - prev_nibble <= nibble every cycle.
  - joypad_irq is registered: joypad_irq <= |(prev_nibble & ~nibble).
  - Result: a single-cycle pulse one clock after any nibble bit goes 1->0.
- Falling edges caused by a select write (newly selected group has a key held) also raise joypad_irq, matching DMG behaviour.
- Rising edges (release) never raise joypad_irq.
- Multiple bits falling in the same cycle produce one pulse.
- Simultaneous press and select write: the nibble is evaluated with the new select value from the following cycle; at most one pulse per falling cycle.
- Reset mid-debounce: the counter is discarded and the key reads released until it is re-qualified after reset.

Decomposition:
- Shared package gb_pkg:
  - P1_ADDR localparam.
  - JOYPAD_IRQ_BIT = 4.
  - Typedef key_idx_t enum {KEY_RIGHT, KEY_LEFT, KEY_UP, KEY_DOWN, KEY_A, KEY_B, KEY_SELECT, KEY_START} for indexing the packed 8-bit key vector.
- Sub-module joypad_debounce:
  - Contains the 2-flop sync, the counter and the stable flop for one key.
  - Parameterised by DEBOUNCE_CYCLES; reset value 1.
  - Instantiated 8 times by a generate loop.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, no keys pressed, read 0xFF00 -> data_out 8'hFF, joypad_irq 0; read 0xFF01 -> 8'h00.
- Write 8'h20 (select directions), hold joypad_up=0 -> P1 reads 8'hEF until clock 6 after the edge, then 8'hEB; joypad_irq pulses high for exactly 1 cycle on the following clock.
- Pulse joypad_a=0 for 3 synced cycles with buttons selected (P1 write 8'h10) -> P1 stays 8'hDF, no irq.
- Hold joypad_start=0 with directions selected, then write 8'h10 -> P1 goes 8'hEF to 8'hD7 and joypad_irq pulses once; release start -> P1 returns 8'hDF with no irq.
- Write 8'h00 with joypad_right=0 and joypad_b=0 held -> nibble 4'hC, P1 reads 8'hCC; write 8'h30 -> P1 reads 8'hFF.
- Assert rst while joypad_down is mid-debounce (counter=2) -> after release of rst, P1 reads the released state, and the press re-qualifies 2+4 clocks later with one irq pulse.
